// File: rtl/rl_lj_position_loader_if.sv
// Position record stream into the LJ position loader (valid/ready handshake).
interface rl_lj_position_loader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_x;
  logic [DATA_WIDTH-1:0] in_y;
  logic [DATA_WIDTH-1:0] in_z;

  // Record source (host / DMA side)
  modport master (
    output in_valid,
    output in_x,
    output in_y,
    output in_z,
    input  in_ready
  );

  // Record sink (loader side)
  modport slave (
    input  in_valid,
    input  in_x,
    input  in_y,
    input  in_z,
    output in_ready
  );
endinterface

// File: rtl/rl_lj_position_loader.sv
// rl_lj_position_loader: writes home-cell records into the reference RAMs and
// neighbor-cell records into the neighbor RAMs, kicks the LJ evaluation unit
// and measures how many cycles it takes to report done.
// Optional watchdog on the evaluation wait: define RL_LJ_LOADER_TIMEOUT_EN.
module rl_lj_position_loader #(
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned REF_PARTICLE_NUM        = 100,
  parameter int unsigned REF_RAM_ADDR_WIDTH      = 7,
  parameter int unsigned NEIGHBOR_PARTICLE_NUM   = 100,
  parameter int unsigned NEIGHBOR_RAM_ADDR_WIDTH = 7,
  parameter int unsigned TIMEOUT_WIDTH           = 16,
  parameter int unsigned DONE_TIMEOUT            = 20000
) (
  input  logic                               clk,
  input  logic                               rst,
  rl_lj_position_loader_if.slave             s_in,
  input  logic                               load_start,
  output logic                               ref_wren,
  output logic [REF_RAM_ADDR_WIDTH-1:0]      ref_wraddr,
  output logic                               nb_wren,
  output logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] nb_wraddr,
  output logic [DATA_WIDTH-1:0]              wr_x,
  output logic [DATA_WIDTH-1:0]              wr_y,
  output logic [DATA_WIDTH-1:0]              wr_z,
  output logic                               eval_start,
  input  logic                               eval_done,
  output logic                               busy,
  output logic                               load_done,
  output logic [TIMEOUT_WIDTH-1:0]           eval_cycles,
  output logic                               timeout_err
);

  localparam logic [REF_RAM_ADDR_WIDTH-1:0] REF_LAST =
    REF_RAM_ADDR_WIDTH'(REF_PARTICLE_NUM - 1);
  localparam logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] NB_LAST =
    NEIGHBOR_RAM_ADDR_WIDTH'(NEIGHBOR_PARTICLE_NUM - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] CYC_MAX      = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    TIMEOUT_WIDTH'(DONE_TIMEOUT - 1);

`ifdef RL_LJ_LOADER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  // Watchdog compiled out: the hit term folds to 0, so timeout_err stays 0.
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REF,
    S_LOAD_NB,
    S_KICK,
    S_WAIT_EVAL
  } state_e;

  state_e                             state_q,       state_d;
  logic [REF_RAM_ADDR_WIDTH-1:0]      ref_cnt_q,     ref_cnt_d;
  logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] nb_cnt_q,      nb_cnt_d;
  logic [TIMEOUT_WIDTH-1:0]           cyc_cnt_q,     cyc_cnt_d;
  logic                               ref_wren_q,    ref_wren_d;
  logic [REF_RAM_ADDR_WIDTH-1:0]      ref_wraddr_q,  ref_wraddr_d;
  logic                               nb_wren_q,     nb_wren_d;
  logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] nb_wraddr_q,   nb_wraddr_d;
  logic [DATA_WIDTH-1:0]              wr_x_q,        wr_x_d;
  logic [DATA_WIDTH-1:0]              wr_y_q,        wr_y_d;
  logic [DATA_WIDTH-1:0]              wr_z_q,        wr_z_d;
  logic                               eval_start_q,  eval_start_d;
  logic                               load_done_q,   load_done_d;
  logic [TIMEOUT_WIDTH-1:0]           eval_cycles_q, eval_cycles_d;
  logic                               timeout_err_q, timeout_err_d;

  logic in_ready_c;
  logic xfer_c;
  logic timeout_hit_c;

  // Handshake decode: records are accepted only while loading.
  always_comb begin
    in_ready_c    = (state_q == S_LOAD_REF) || (state_q == S_LOAD_NB);
    xfer_c        = s_in.in_valid & in_ready_c;
    timeout_hit_c = TIMEOUT_EN && (cyc_cnt_q == TIMEOUT_LAST) && !eval_done;
  end

  assign s_in.in_ready = in_ready_c;
  assign busy          = (state_q != S_IDLE);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    ref_cnt_d     = ref_cnt_q;
    nb_cnt_d      = nb_cnt_q;
    cyc_cnt_d     = cyc_cnt_q;
    ref_wren_d    = 1'b0;
    ref_wraddr_d  = ref_wraddr_q;
    nb_wren_d     = 1'b0;
    nb_wraddr_d   = nb_wraddr_q;
    wr_x_d        = wr_x_q;
    wr_y_d        = wr_y_q;
    wr_z_d        = wr_z_q;
    eval_start_d  = 1'b0;
    load_done_d   = 1'b0;
    eval_cycles_d = eval_cycles_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        ref_cnt_d = '0;
        nb_cnt_d  = '0;
        if (load_start) begin
          state_d       = S_LOAD_REF;
          timeout_err_d = 1'b0;
        end
      end

      S_LOAD_REF: begin
        if (xfer_c) begin
          wr_x_d       = s_in.in_x;
          wr_y_d       = s_in.in_y;
          wr_z_d       = s_in.in_z;
          ref_wraddr_d = ref_cnt_q;
          ref_wren_d   = 1'b1;
          ref_cnt_d    = ref_cnt_q + REF_RAM_ADDR_WIDTH'(1);
          if (ref_cnt_q == REF_LAST) begin
            state_d = S_LOAD_NB;
          end
        end
      end

      S_LOAD_NB: begin
        if (xfer_c) begin
          wr_x_d      = s_in.in_x;
          wr_y_d      = s_in.in_y;
          wr_z_d      = s_in.in_z;
          nb_wraddr_d = nb_cnt_q;
          nb_wren_d   = 1'b1;
          nb_cnt_d    = nb_cnt_q + NEIGHBOR_RAM_ADDR_WIDTH'(1);
          if (nb_cnt_q == NB_LAST) begin
            state_d = S_KICK;
          end
        end
      end

      // The last neighbor strobe is on the wires this cycle; start follows it.
      S_KICK: begin
        eval_start_d = 1'b1;
        cyc_cnt_d    = '0;
        state_d      = S_WAIT_EVAL;
      end

      S_WAIT_EVAL: begin
        if (!eval_done && (cyc_cnt_q != CYC_MAX)) begin
          cyc_cnt_d = cyc_cnt_q + TIMEOUT_WIDTH'(1);
        end
        if (eval_done) begin
          eval_cycles_d = cyc_cnt_q;
          load_done_d   = 1'b1;
          state_d       = S_IDLE;
        end else if (timeout_hit_c) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ref_cnt_q     <= '0;
      nb_cnt_q      <= '0;
      cyc_cnt_q     <= '0;
      ref_wren_q    <= 1'b0;
      ref_wraddr_q  <= '0;
      nb_wren_q     <= 1'b0;
      nb_wraddr_q   <= '0;
      wr_x_q        <= '0;
      wr_y_q        <= '0;
      wr_z_q        <= '0;
      eval_start_q  <= 1'b0;
      load_done_q   <= 1'b0;
      eval_cycles_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_cnt_q     <= ref_cnt_d;
      nb_cnt_q      <= nb_cnt_d;
      cyc_cnt_q     <= cyc_cnt_d;
      ref_wren_q    <= ref_wren_d;
      ref_wraddr_q  <= ref_wraddr_d;
      nb_wren_q     <= nb_wren_d;
      nb_wraddr_q   <= nb_wraddr_d;
      wr_x_q        <= wr_x_d;
      wr_y_q        <= wr_y_d;
      wr_z_q        <= wr_z_d;
      eval_start_q  <= eval_start_d;
      load_done_q   <= load_done_d;
      eval_cycles_q <= eval_cycles_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ref_wren    = ref_wren_q;
  assign ref_wraddr  = ref_wraddr_q;
  assign nb_wren     = nb_wren_q;
  assign nb_wraddr   = nb_wraddr_q;
  assign wr_x        = wr_x_q;
  assign wr_y        = wr_y_q;
  assign wr_z        = wr_z_q;
  assign eval_start  = eval_start_q;
  assign load_done   = load_done_q;
  assign eval_cycles = eval_cycles_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/rl_lj_position_loader.md
# rl_lj_position_loader

Host-side writer and initiator for the range-limited LJ evaluation unit. Accepts a stream of particle positions, writes the home-cell records into the reference position RAMs and the neighbor-cell records into the neighbor position RAMs, then pulses the evaluation unit's `start`. It waits for `done` and reports completion, evaluation cycle count and a watchdog timeout. It sits between the host/DMA stream and the evaluation unit's RAM write ports and `start`/`done` pins.

## Interface
Parameters:
- DATA_WIDTH, 32: width of one IEEE-754 coordinate.
- REF_PARTICLE_NUM, 100: number of home-cell records per load.
- REF_RAM_ADDR_WIDTH, 7: reference RAM address width.
- NEIGHBOR_PARTICLE_NUM, 100: number of neighbor-cell records per load.
- NEIGHBOR_RAM_ADDR_WIDTH, 7: neighbor RAM address width.
- TIMEOUT_WIDTH, 16: width of the cycle counter and `eval_cycles`.
- DONE_TIMEOUT, 20000: watchdog limit in WAIT_EVAL cycles. Must be ≤ 2^TIMEOUT_WIDTH−1.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- load_start  in  1  starts a load. Sampled only in IDLE.
- in_valid  in  1  a position record is present on in_x/y/z.
- in_ready  out  1  loader accepts a record this cycle.
- in_x, in_y, in_z  in  DATA_WIDTH each  record coordinates.
- ref_wren  out  1  write strobe to ref_x/y/z RAMs.
- ref_wraddr  out  REF_RAM_ADDR_WIDTH  reference RAM write address.
- nb_wren  out  1  write strobe to neighbor_x/y/z RAMs.
- nb_wraddr  out  NEIGHBOR_RAM_ADDR_WIDTH  neighbor RAM write address.
- wr_x, wr_y, wr_z  out  DATA_WIDTH each  shared write data for both RAM sets.
- eval_start  out  1  start pulse to the evaluation unit.
- eval_done  in  1  done pulse from the evaluation unit.
- busy  out  1  high in every state except IDLE.
- load_done  out  1  one-cycle completion pulse.
- eval_cycles  out  TIMEOUT_WIDTH  cycle count of the last completed evaluation.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, LOAD_REF, LOAD_NB, KICK, WAIT_EVAL.
- IDLE: if `load_start`=1, go to LOAD_REF and clear `timeout_err`. Address counters reset to 0.
- `in_ready` is a combinational decode: 1 in LOAD_REF or LOAD_NB, 0 otherwise. A transfer occurs on any edge where `in_valid`&`in_ready`.
- LOAD_REF: each transfer registers the record onto wr_x/y/z, sets `ref_wraddr` = ref counter, and asserts `ref_wren` for the next cycle. The counter then increments. The transfer at count REF_PARTICLE_NUM−1 moves the state to LOAD_NB.
- LOAD_NB: same behaviour using `nb_wren`/`nb_wraddr`. The transfer at count NEIGHBOR_PARTICLE_NUM−1 moves the state to KICK.
- Write strobes are 1 only in the cycle after a transfer. Cycles without a transfer write nothing. wr_x/y/z hold their last value.
- KICK: `eval_start`<=1, cycle counter<=0, go to WAIT_EVAL.
- WAIT_EVAL: `eval_start`<=0 after one cycle. The counter increments on every cycle where `eval_done`=0.
  - On `eval_done`=1: `eval_cycles`<=counter, `load_done`<=1 for one cycle, go to IDLE.
- Ignored events:
  - `load_start` outside IDLE.
  - `eval_done` outside WAIT_EVAL.
  - `in_valid` outside the LOAD states.
- Counter saturates at 2^TIMEOUT_WIDTH−1 and never wraps.
- Reset (any state): go to IDLE. All counters and outputs return to 0. RAM contents are not cleared.

## Timing
- Reset values: in_ready=0, ref_wren=0, nb_wren=0, ref_wraddr=0, nb_wraddr=0, wr_x/y/z=0, eval_start=0, busy=0, load_done=0, eval_cycles=0, timeout_err=0.
- All outputs are registered except `in_ready` and `busy`, which are state decodes.
- Write latency is one cycle from transfer edge to write strobe.
- The last neighbor write occurs in cycle L. `eval_start` is high in cycle L+1 only, so the write is committed before the evaluation unit reads.
- Minimum load with no stream gaps: REF+NB cycles of LOAD, 1 cycle of KICK, then WAIT_EVAL.
- `load_done` is high in the cycle after `eval_done` is sampled.

## Configuration
- Macro `RL_LJ_LOADER_TIMEOUT_EN`.
- Defined: in WAIT_EVAL, when counter = DONE_TIMEOUT−1 and `eval_done`=0, set `timeout_err`<=1, go to IDLE, and do not pulse `load_done`. If `eval_done`=1 on that same cycle, done wins.
- Undefined: WAIT_EVAL waits indefinitely and `timeout_err` is tied to 0. The counter and `eval_cycles` are unchanged.

## Test plan
- **Basic load:** REF=NB=4, `load_start`, 8 back-to-back records with x=1..8 → ref_wren at addr 0..3 with wr_x=1..4, then nb_wren at addr 0..3 with wr_x=5..8. `eval_start` is high exactly once, one cycle after the last nb write.
- **Stream gaps:** deassert `in_valid` every other cycle → same addresses and data, no spurious strobes, `in_ready` held 1 throughout.
- **Normal completion:** `eval_done` 50 cycles after `eval_start` → eval_cycles=50, load_done high one cycle, busy=0 on the next cycle.
- **Watchdog:** with the macro defined, DONE_TIMEOUT=100 and no `eval_done` → timeout_err=1 after 100 WAIT_EVAL cycles, load_done never asserts, next `load_start` clears the flag.
- **Reset mid-load:** rst=0 after the second neighbor record → every output is 0 and state is IDLE. A new full load then restarts at ref addr 0.
- **Ignored inputs:** `load_start` pulsed in LOAD_NB and `eval_done` pulsed in IDLE → no state change and no extra `eval_start`/`load_done`.
